uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver, 8N1, LSB first, the receiving end of the design's `uart_tx` link. It samples an external serial pin, recovers one byte per frame by mid-bit sampling, and presents each byte with a single-cycle valid strobe. It sits beside `uart_tx` in the top level, driven by the same `clk` and `reset` from the input pins, with `rx_pin` taken from a spare input bit.

## Interface
- `CLOCK_RATE`, default 1000: `clk` frequency in Hz.
- `BAUD_RATE`, default 100: serial bit rate in bits/s.
- Derived `CPB = CLOCK_RATE / BAUD_RATE` (integer division): clocks per bit. `CPB >= 4` is required; smaller values are unsupported.
- Derived `HALF = CPB / 2` (floor).

Ports:
- `clk`  in  1: sole clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-low reset; while low, all state is held at its reset values.
- `rx_pin`  in  1: serial input, asynchronous to `clk`; idle level high.
- `data`  out  8: last correctly received byte. Reset value 0x00.
- `valid`  out  1: one-cycle pulse when `data` has just been updated. Reset value 0.
- `frame_err`  out  1: one-cycle pulse when a frame's stop bit samples low. Reset value 0.
- `busy`  out  1: high while a frame is in progress. Reset value 0.

## Operation
- Synchronizer: `rx_pin` passes through two flops, both reset to 1. The FSM uses only the synchronized value `rxs`.
- One bit counter (0..CPB-1) and one 3-bit data index.
- States:
  - IDLE: `busy=0`. If `rxs==0`, go to START and load the counter for HALF clocks.
  - START: at expiry, sample `rxs`.
    - If it is 1 (glitch or false start), return to IDLE. No strobe is raised.
    - If it is 0, go to DATA with index 0 and load the counter for CPB clocks.
  - DATA: at each expiry, shift `rxs` into the shift register at bit `index` (LSB first) and reload CPB. After index 7, go to STOP.
  - STOP: at expiry (CPB after bit 7), sample `rxs`.
    - If it is 1, load the shift register into `data`, pulse `valid`, and go to IDLE.
    - If it is 0, pulse `frame_err`, leave `data` unchanged, and go to BREAK.
  - BREAK: wait until `rxs==1`, then go to IDLE. This prevents a held-low line from being received as repeated 0x00 frames.
- `busy=1` in START, DATA, STOP and BREAK.
- `valid` and `frame_err` are never high together. Each is high for exactly one cycle per frame.
- `data` holds its value indefinitely between valid frames.
- Reset asserted at any point, including mid-frame, clears immediately to IDLE, all outputs to their reset values, and both synchronizer flops to 1. No strobe is issued for the aborted frame.
- A new start bit is accepted from the first IDLE cycle after STOP, so back-to-back frames with a one-bit stop are supported.

## Timing
- Let t0 be the rising edge at which the first synchronizer flop first captures `rx_pin==0`.
- IDLE→START at edge t0+2; `busy` is high from that edge.
- Start-bit sample at edge t0+2+HALF.
- Data bit i (0..7) sampled at edge t0+2+HALF+(i+1)·CPB.
- Stop sample at edge S = t0+2+HALF+9·CPB.
  - `data`, `valid` or `frame_err`, and the return to IDLE are all registered at edge S.
  - The strobe is therefore high during the cycle after S.
  - `busy` is low from S on a good frame.
- Defaults (CPB=10, HALF=5): S = t0+97.
- Latency from the pin to `valid` is 2 synchronizer cycles plus the frame time.

## Test plan
- Send 0xA5 at default parameters, frame bits 0,1,0,1,0,0,1,0,1,1, each 10 clocks → `valid` for exactly 1 cycle at t0+98, `data=0xA5`, `frame_err` never high, `busy` high t0+2..t0+96.
- Send 0x00 then 0xFF back-to-back, no idle gap → two `valid` pulses 100 clocks apart, `data` 0x00 then 0xFF.
- Low glitch of 3 clocks on `rx_pin` from idle → `busy` high, then low after the start sample; no `valid` or `frame_err`; `data` unchanged.
- Send 0x3C with the stop bit driven low, then hold the line low for 50 clocks → one `frame_err` pulse, `data` keeps its previous value, `busy` stays high until the line returns high, no further strobes.
- Assert `reset` low mid-byte (after 4 data bits) for 2 clocks, then send 0x81 → all outputs 0 during reset, no strobe for the aborted frame, then `valid` with `data=0x81`.
- CLOCK_RATE=1000, BAUD_RATE=250 (CPB=4, HALF=2), send 0x5A → `valid` at t0+2+2+36+1 = t0+41, `data=0x5A`.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop input synchronizer, mid-bit sampling FSM,
// one-cycle valid / frame_err strobes and a break state for held-low lines.
module uart_rx #(
  parameter int CLOCK_RATE = 1000,
  parameter int BAUD_RATE  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_pin,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CPB   = CLOCK_RATE / BAUD_RATE;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] LOAD_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] LOAD_BIT  = CNT_W'(CPB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [7:0]       data_nxt;
  logic             valid_nxt, ferr_nxt;
  logic             rx_sync_p0, rx_sync_p1;
  logic             rxs;
  logic             expired;

  // Synchronizer stage: both flops idle high so reset never looks like a start bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= rx_pin;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  assign rxs     = rx_sync_p1;
  assign expired = (cnt == '0);
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = expired ? cnt : cnt - 1'b1;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    data_nxt  = data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rxs) begin
          state_nxt = S_START;
          cnt_nxt   = LOAD_HALF;
        end
      end
      S_START: begin
        if (expired) begin
          if (rxs) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DATA;
            idx_nxt   = 3'd0;
            cnt_nxt   = LOAD_BIT;
          end
        end
      end
      S_DATA: begin
        if (expired) begin
          shreg_nxt[idx] = rxs;
          cnt_nxt        = LOAD_BIT;
          if (idx == 3'd7) begin
            state_nxt = S_STOP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (expired) begin
          if (rxs) begin
            data_nxt  = shreg;
            valid_nxt = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A line held low must rise before another start bit is honoured
        if (rxs) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control and output register stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      shreg     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      shreg     <= shreg_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
      frame_err <= ferr_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames go out on the pin, expected strobes
// (kind, byte, cycle) are queued, and monitors pop and compare on each strobe.
module tb_uart_rx;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
    int         at;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic [7:0] data0, data1;
  logic       valid0, valid1, ferr0, ferr1, busy0, busy1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic [7:0] last_good [2];

  uart_rx u_dut (
    .clk(clk), .reset(reset), .rx_pin(rx0),
    .data(data0), .valid(valid0), .frame_err(ferr0), .busy(busy0)
  );

  uart_rx #(.CLOCK_RATE(1000), .BAUD_RATE(250)) u_dut4 (
    .clk(clk), .reset(reset), .rx_pin(rx1),
    .data(data1), .valid(valid1), .frame_err(ferr1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitors: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset) begin
      if (valid0 && ferr0) chk("dut0_both_strobes", 1, 0);
      if (valid0 || ferr0) begin
        if (q0.size() == 0) begin
          chk("dut0_unexpected_strobe", {30'd0, valid0, ferr0}, 0);
        end else begin
          e0 = q0.pop_front();
          chk("dut0_kind", {31'd0, ferr0}, {31'd0, e0.is_err});
          chk("dut0_data", {24'd0, data0}, {24'd0, e0.d});
          chk("dut0_cycle", cyc, e0.at);
        end
      end
      if (valid1 && ferr1) chk("dut4_both_strobes", 1, 0);
      if (valid1 || ferr1) begin
        if (q1.size() == 0) begin
          chk("dut4_unexpected_strobe", {30'd0, valid1, ferr1}, 0);
        end else begin
          e1 = q1.pop_front();
          chk("dut4_kind", {31'd0, ferr1}, {31'd0, e1.is_err});
          chk("dut4_data", {24'd0, data1}, {24'd0, e1.d});
          chk("dut4_cycle", cyc, e1.at);
        end
      end
    end
  end

  task automatic drive(input int sel, input logic v);
    if (sel != 0) rx1 = v;
    else          rx0 = v;
  endtask

  // Called at a negedge; the first sync flop sees the start bit at edge cyc+1
  task automatic send(input int sel, input logic [7:0] b, input bit stop_ok, input int hold);
    int   cpb;
    int   half;
    logic v;
    exp_t e;
    cpb      = (sel != 0) ? 4 : 10;
    half     = cpb / 2;
    e.is_err = !stop_ok;
    e.d      = stop_ok ? b : last_good[sel];
    e.at     = cyc + 1 + 2 + half + 9 * cpb;
    if (sel != 0) q1.push_back(e);
    else          q0.push_back(e);
    if (stop_ok) last_good[sel] = b;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      v = 1'b0;
      else if (i == 9) v = stop_ok;
      else             v = b[i-1];
      drive(sel, v);
      repeat (cpb) @(negedge clk);
    end
    if (!stop_ok) begin
      repeat (hold) @(negedge clk);
      chk("break_busy_held", {31'd0, (sel != 0) ? busy1 : busy0}, 1);
      drive(sel, 1'b1);
      repeat (5) @(negedge clk);
      chk("break_busy_released", {31'd0, (sel != 0) ? busy1 : busy0}, 0);
    end
  endtask

  initial begin
    int   wait_cnt;
    logic [7:0] abort_byte;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_data", {24'd0, data0}, 0);
    chk("rst_valid", {31'd0, valid0}, 0);
    chk("rst_ferr", {31'd0, ferr0}, 0);
    chk("rst_busy", {31'd0, busy0}, 0);
    chk("rst_data4", {24'd0, data1}, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    send(0, 8'hA5, 1'b1, 0);
    repeat (7) @(negedge clk);
    chk("a5_data_holds", {24'd0, data0}, 8'hA5);

    send(0, 8'h00, 1'b1, 0);
    send(0, 8'hFF, 1'b1, 0);
    repeat (4) @(negedge clk);

    // Short low glitch: start sample finds the line high again
    rx0 = 1'b0;
    repeat (3) @(negedge clk);
    rx0 = 1'b1;
    chk("glitch_busy_high", {31'd0, busy0}, 1);
    repeat (8) @(negedge clk);
    chk("glitch_busy_low", {31'd0, busy0}, 0);
    chk("glitch_data_kept", {24'd0, data0}, {24'd0, last_good[0]});

    send(0, 8'h3C, 1'b0, 50);
    chk("ferr_data_kept", {24'd0, data0}, 8'hFF);
    repeat (5) @(negedge clk);

    // Reset mid-byte, after four data bits of an unqueued frame
    abort_byte = 8'hC3;
    rx0 = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx0 = abort_byte[i];
      repeat (10) @(negedge clk);
    end
    rx0 = abort_byte[4];
    repeat (4) @(negedge clk);
    reset = 1'b0;
    rx0 = 1'b1;
    @(negedge clk);
    chk("midrst_data", {24'd0, data0}, 0);
    chk("midrst_valid", {31'd0, valid0}, 0);
    chk("midrst_ferr", {31'd0, ferr0}, 0);
    chk("midrst_busy", {31'd0, busy0}, 0);
    @(negedge clk);
    reset = 1'b1;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    repeat (5) @(negedge clk);
    send(0, 8'h81, 1'b1, 0);

    send(1, 8'h5A, 1'b1, 0);

    for (int n = 0; n < 24; n++) begin
      int sel;
      sel = (n % 3 == 2) ? 1 : 0;
      send(sel, 8'($urandom), ($urandom_range(0, 4) != 0), $urandom_range(0, 30));
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 15)) @(negedge clk);
    end

    wait_cnt = 0;
    while ((q0.size() + q1.size()) != 0 && wait_cnt < 300) begin
      @(negedge clk);
      wait_cnt++;
    end
    repeat (3) @(negedge clk);
    chk("queues_drained", q0.size() + q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
